// File: rtl/adxl_z_reader_pkg.sv
// Shared constants for the ADXL345 Z-axis reader: register map, config
// values, read command and the state encodings of both state machines.
package adxl_z_reader_pkg;

    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;

    // 4-wire SPI, +/-2 g, 10-bit right-justified
    localparam logic [7:0] VAL_DATA_FORMAT  = 8'h00;
    // 100 Hz output data rate
    localparam logic [7:0] VAL_BW_RATE      = 8'h0A;
    // measurement mode
    localparam logic [7:0] VAL_POWER_CTL    = 8'h08;

    // R=1, MB=1, address DATAZ0: reads DATAZ0 then DATAZ1
    localparam logic [7:0] CMD_READ_Z       = {2'b11, ADDR_DATAZ0};

    typedef enum logic [2:0] {
        PWRUP, CFG_FMT, CFG_BW, CFG_PWR, GAP, IDLE, RD_Z, UPDATE
    } state_t;

    typedef enum logic [1:0] {
        ENG_IDLE, ENG_LEAD, ENG_SHIFT, ENG_TRAIL
    } eng_phase_t;

    // Single-register write frame: {R=0, MB=0, addr[5:0]}, data
    function automatic logic [15:0] write_frame(input logic [5:0] addr, input logic [7:0] data);
        return {2'b00, addr, data};
    endfunction

endpackage

// File: rtl/adxl_z_reader_spi_byte_engine.sv
// Mode-3 SPI master that shifts one 16- or 24-bit frame per start request.
// CS leads the first SCLK fall and trails the last SCLK rise by CLK_DIV
// cycles; done pulses right after the last rising edge so the caller can
// use the received word before CS has released.
module spi_byte_engine
    import adxl_z_reader_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        frame24,
    input  logic [23:0] tx_data,
    input  logic        miso,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic [23:0] rx_data
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    eng_phase_t        phase_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [4:0]        bit_cnt_reg;
    logic [23:0]       shift_reg;
    logic [23:0]       rx_reg;
    logic              sclk_reg;
    logic              cs_n_reg;
    logic              mosi_reg;
    logic              done_reg;
    logic              div_hit;

    assign div_hit = (div_cnt_reg == DIV_LAST);

    // Half-period timer, bit sequencing and both shift registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg   <= ENG_IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            rx_reg      <= '0;
            sclk_reg    <= 1'b1;
            cs_n_reg    <= 1'b1;
            mosi_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (phase_reg != ENG_IDLE && !div_hit)
                div_cnt_reg <= div_cnt_reg + 1'b1;
            else
                div_cnt_reg <= '0;

            case (phase_reg)
                ENG_IDLE: begin
                    if (start) begin
                        cs_n_reg    <= 1'b0;
                        phase_reg   <= ENG_LEAD;
                        // 16-bit frames are left-aligned so bit 23 is always next out
                        shift_reg   <= frame24 ? tx_data : {tx_data[15:0], 8'h00};
                        bit_cnt_reg <= frame24 ? 5'd24 : 5'd16;
                        rx_reg      <= '0;
                    end
                end
                ENG_LEAD: begin
                    if (div_hit) begin
                        sclk_reg  <= 1'b0;
                        mosi_reg  <= shift_reg[23];
                        shift_reg <= {shift_reg[22:0], 1'b0};
                        phase_reg <= ENG_SHIFT;
                    end
                end
                ENG_SHIFT: begin
                    if (div_hit) begin
                        if (!sclk_reg) begin
                            sclk_reg    <= 1'b1;
                            rx_reg      <= {rx_reg[22:0], miso};
                            bit_cnt_reg <= bit_cnt_reg - 1'b1;
                            if (bit_cnt_reg == 5'd1) begin
                                done_reg  <= 1'b1;
                                phase_reg <= ENG_TRAIL;
                            end
                        end else begin
                            sclk_reg  <= 1'b0;
                            mosi_reg  <= shift_reg[23];
                            shift_reg <= {shift_reg[22:0], 1'b0};
                        end
                    end
                end
                ENG_TRAIL: begin
                    if (div_hit) begin
                        cs_n_reg  <= 1'b1;
                        mosi_reg  <= 1'b0;
                        phase_reg <= ENG_IDLE;
                    end
                end
                default: phase_reg <= ENG_IDLE;
            endcase
        end
    end

    assign sclk    = sclk_reg;
    assign cs_n    = cs_n_reg;
    assign mosi    = mosi_reg;
    assign busy    = (phase_reg != ENG_IDLE);
    assign done    = done_reg;
    assign rx_data = rx_reg;

endmodule

// File: rtl/adxl_z_reader.sv
// ADXL345 Z-axis reader: waits for sensor power-up, writes the three
// configuration registers, then reads DATAZ0/DATAZ1 on every sample tick
// and presents the 10-bit two's-complement result with a one-cycle strobe.
module adxl_z_reader
    import adxl_z_reader_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int PWRUP_WAIT = 100000,
    parameter int SAMPLE_DIV = 500000,
    parameter int CS_GAP     = 50
) (
    input  logic       clk,
    input  logic       rst,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso,
    input  logic       int2_in,
    output logic       int2_sync,
    output logic [9:0] z_data,
    output logic       z_valid,
    output logic       init_done
);

    localparam int PW_W  = (PWRUP_WAIT > 1) ? $clog2(PWRUP_WAIT) : 1;
    localparam int SMP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_t             state_reg, state_next;
    state_t             ret_reg, ret_next;
    logic               start_reg, start_next;
    logic               clr_pending;
    logic [PW_W-1:0]    pwr_cnt_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic [SMP_W-1:0]   smp_cnt_reg;
    logic               pending_reg;
    logic               init_done_reg;
    logic [9:0]         z_data_reg;
    logic               int2_meta_reg, int2_sync_reg;

    logic               eng_busy, eng_done, eng_frame24;
    logic [23:0]        eng_tx, eng_rx;
    logic               pwr_done, gap_done, smp_tick;
    logic               unused_rx;

    assign pwr_done = (pwr_cnt_reg == PW_W'(PWRUP_WAIT - 1));
    assign gap_done = !eng_busy && (gap_cnt_reg == GAP_W'(CS_GAP - 1));
    assign smp_tick = (smp_cnt_reg == SMP_W'(SAMPLE_DIV - 1));

    spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk     (clk),
        .rst     (rst),
        .start   (start_reg),
        .frame24 (eng_frame24),
        .tx_data (eng_tx),
        .miso    (spi_miso),
        .sclk    (spi_sclk),
        .cs_n    (spi_cs_n),
        .mosi    (spi_mosi),
        .busy    (eng_busy),
        .done    (eng_done),
        .rx_data (eng_rx)
    );

    // Frame to send is chosen by the transaction state currently active
    always_comb begin
        eng_tx      = '0;
        eng_frame24 = 1'b0;
        case (state_reg)
            CFG_FMT: eng_tx = {8'h00, write_frame(ADDR_DATA_FORMAT, VAL_DATA_FORMAT)};
            CFG_BW:  eng_tx = {8'h00, write_frame(ADDR_BW_RATE, VAL_BW_RATE)};
            CFG_PWR: eng_tx = {8'h00, write_frame(ADDR_POWER_CTL, VAL_POWER_CTL)};
            RD_Z: begin
                eng_tx      = {CMD_READ_Z, 16'h0000};
                eng_frame24 = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic; GAP returns to whichever state was queued in ret_reg
    always_comb begin
        state_next  = state_reg;
        ret_next    = ret_reg;
        clr_pending = 1'b0;
        case (state_reg)
            PWRUP:   if (pwr_done) state_next = CFG_FMT;
            CFG_FMT: if (eng_done) begin state_next = GAP; ret_next = CFG_BW;  end
            CFG_BW:  if (eng_done) begin state_next = GAP; ret_next = CFG_PWR; end
            CFG_PWR: if (eng_done) begin state_next = GAP; ret_next = IDLE;    end
            GAP:     if (gap_done) state_next = ret_reg;
            IDLE: begin
                if (pending_reg) begin
                    state_next  = RD_Z;
                    clr_pending = 1'b1;
                end
            end
            RD_Z:    if (eng_done) state_next = UPDATE;
            UPDATE: begin
                state_next = GAP;
                ret_next   = IDLE;
            end
            default: state_next = PWRUP;
        endcase
        // Kick the engine once on entry to any transaction state
        start_next = (state_next != state_reg) &&
                     (state_next inside {CFG_FMT, CFG_BW, CFG_PWR, RD_Z});
    end

    // State register, power-up and CS-gap timers, init flag and Z capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= PWRUP;
            ret_reg       <= IDLE;
            start_reg     <= 1'b0;
            pwr_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            init_done_reg <= 1'b0;
            z_data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            ret_reg     <= ret_next;
            start_reg   <= start_next;
            pwr_cnt_reg <= (state_reg == PWRUP && !pwr_done) ? pwr_cnt_reg + 1'b1 : '0;
            // Gap only counts once CS is really high, i.e. the engine has released it
            gap_cnt_reg <= (state_reg == GAP && eng_busy == 1'b0) ? gap_cnt_reg + 1'b1 : '0;
            if (state_next == IDLE)
                init_done_reg <= 1'b1;
            if (state_reg == RD_Z && eng_done)
                z_data_reg <= {eng_rx[1:0], eng_rx[15:8]};
        end
    end

    // Free-running sample divider; one pending request, extra ticks are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp_cnt_reg <= '0;
            pending_reg <= 1'b0;
        end else begin
            smp_cnt_reg <= smp_tick ? '0 : smp_cnt_reg + 1'b1;
            if (smp_tick)
                pending_reg <= 1'b1;
            else if (clr_pending)
                pending_reg <= 1'b0;
        end
    end

    // Two-flop synchronizer for the asynchronous INT2 pin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int2_meta_reg <= 1'b0;
            int2_sync_reg <= 1'b0;
        end else begin
            int2_meta_reg <= int2_in;
            int2_sync_reg <= int2_meta_reg;
        end
    end

    // Command-phase bits and DATAZ1[7:2] carry no Z information
    assign unused_rx = ^{eng_rx[23:16], eng_rx[7:2]};

    assign z_data    = z_data_reg;
    assign z_valid   = (state_reg == UPDATE);
    assign init_done = init_done_reg;
    assign int2_sync = int2_sync_reg;

endmodule

// File: tb/tb_adxl_z_reader.sv
// Bench for adxl_z_reader: an ADXL345-like SPI slave supplies random or
// fixed Z samples, and a monitor compares every output against values the
// slave and the sample-rate rules predict.
module tb_adxl_z_reader;

    localparam int CLK_DIV    = 4;
    localparam int PWRUP_WAIT = 200;
    localparam int SAMPLE_DIV = 400;
    localparam int CS_GAP     = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_miso = 1'b0;
    logic       int2_in = 1'b0;
    logic       spi_sclk, spi_cs_n, spi_mosi, int2_sync, z_valid, init_done;
    logic [9:0] z_data;

    adxl_z_reader #(
        .CLK_DIV(CLK_DIV), .PWRUP_WAIT(PWRUP_WAIT),
        .SAMPLE_DIV(SAMPLE_DIV), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .int2_in(int2_in), .int2_sync(int2_sync),
        .z_data(z_data), .z_valid(z_valid), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // ---------------- SPI slave model (mode 3) ----------------
    logic [23:0] frame_q[$];
    int          len_q[$];
    logic [9:0]  exp_z[$];
    bit          use_fixed = 1'b1;
    logic [7:0]  fix0 = 8'h34, fix1 = 8'h03;
    logic [7:0]  dz0 = '0, dz1 = '0;
    logic [23:0] sl_in = '0, sl_out = '0;
    int          sl_bits = 0;
    logic        sl_cs_prev = 1'b1, sl_sclk_prev = 1'b1;

    always @(spi_cs_n or spi_sclk) begin
        if (spi_cs_n !== sl_cs_prev) begin
            if (spi_cs_n === 1'b0) begin
                sl_in = '0;
                sl_bits = 0;
                if (use_fixed) begin
                    dz0 = fix0; dz1 = fix1;
                end else begin
                    dz0 = 8'($urandom); dz1 = 8'($urandom);
                end
                sl_out = {8'h00, dz0, dz1};
            end else if (spi_cs_n === 1'b1 && sl_bits > 0) begin
                frame_q.push_back(sl_in);
                len_q.push_back(sl_bits);
                if (sl_bits == 24)
                    check_val("rd_mosi_zero", 32'(sl_in[15:0]), 32'h0);
            end
        end
        if (spi_sclk !== sl_sclk_prev && spi_cs_n === 1'b0) begin
            if (spi_sclk === 1'b1) begin
                sl_in = {sl_in[22:0], spi_mosi};
                sl_bits++;
                if (sl_bits == 24 && sl_in[23:16] == 8'hF6)
                    exp_z.push_back({dz1[1:0], dz0});
            end else if (spi_sclk === 1'b0) begin
                spi_miso = sl_out[23];
                sl_out = {sl_out[22:0], 1'b0};
            end
        end
        sl_cs_prev = spi_cs_n;
        sl_sclk_prev = spi_sclk;
    end

    // ---------------- INT2 driver (mid-cycle, away from edges) ----------------
    int int2_req = 0;
    int int2_served = 0;
    int int2_left = 0;
    bit int2_rand = 1'b0;

    initial forever begin
        @(posedge clk);
        #2;
        if (int2_req != int2_served) begin
            int2_served = int2_req;
            int2_left = 3;
        end
        if (int2_left > 0) begin
            int2_in = 1'b1;
            int2_left--;
        end else if (int2_rand) begin
            int2_in = 1'($urandom_range(0, 1));
        end else begin
            int2_in = 1'b0;
        end
    end

    // ---------------- Monitor ----------------
    int   last_rise = 0, last_zv = 0, nval = 0, cs_rise_cyc = 0, first_cs_fall = -1, since_rst = 0;
    int   intv;
    bit   cs_seen_rise = 1'b0;
    logic prev_sclk = 1'b1, prev_cs = 1'b1, prev_zv = 1'b0, h1 = 1'b0, h2 = 1'b0;
    logic [9:0] z_held = '0;
    logic [9:0] z_want;

    always @(negedge clk) begin
        if (!rst) begin
            nval = 0;
            cs_seen_rise = 1'b0;
            first_cs_fall = -1;
            z_held = '0;
            since_rst = 0;
        end else begin
            since_rst++;
            if (spi_sclk && !prev_sclk && !spi_cs_n)
                last_rise = cyc;
            if (!spi_cs_n && prev_cs) begin
                if (first_cs_fall < 0)
                    first_cs_fall = cyc;
                if (cs_seen_rise)
                    check_val("cs_gap_ok", 32'(cyc - cs_rise_cyc >= CS_GAP), 32'd1);
            end
            if (spi_cs_n && !prev_cs) begin
                cs_rise_cyc = cyc;
                cs_seen_rise = 1'b1;
            end
            if (z_valid) begin
                check_val("zv_single", 32'(prev_zv), 32'd0);
                check_val("zv_latency", 32'(cyc - last_rise), 32'd1);
                if (exp_z.size() == 0) begin
                    check_val("zv_unexpected", 32'd1, 32'd0);
                end else begin
                    z_want = exp_z.pop_front();
                    check_val("z_data", 32'(z_data), 32'(z_want));
                    z_held = z_want;
                end
                if (nval >= 1) begin
                    intv = cyc - last_zv;
                    check_val("rd_interval_ok",
                              32'(intv >= CS_GAP + 48 * CLK_DIV && intv < 2 * SAMPLE_DIV), 32'd1);
                    if (nval >= 5)
                        check_val("rd_period", 32'(intv), 32'(SAMPLE_DIV));
                end
                last_zv = cyc;
                nval++;
            end else begin
                check_val("z_hold", 32'(z_data), 32'(z_held));
            end
            if (since_rst > 2)
                check_val("int2_sync", 32'(int2_sync), 32'(h2));
        end
        h2 = h1;
        h1 = int2_in;
        prev_sclk = spi_sclk;
        prev_cs = spi_cs_n;
        prev_zv = z_valid;
    end

    // ---------------- Helpers ----------------
    task automatic wait_for_init(input int bound);
        int n = 0;
        while (!init_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_val("init_done_seen", 32'(init_done), 32'd1);
    endtask

    task automatic wait_for_zv(input int bound);
        int n = 0;
        @(negedge clk);
        while (!z_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_val("zv_seen", 32'(z_valid), 32'd1);
    endtask

    task automatic check_cfg(input int base, input int rel_cyc);
        logic [15:0] cfg_exp [3];
        cfg_exp[0] = 16'h3100;
        cfg_exp[1] = 16'h2C0A;
        cfg_exp[2] = 16'h2D08;
        check_val("cfg_count", 32'(frame_q.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (frame_q.size() > base + i) begin
                check_val($sformatf("cfg_frame%0d", i), 32'(frame_q[base + i][15:0]), 32'(cfg_exp[i]));
                check_val($sformatf("cfg_len%0d", i), 32'(len_q[base + i]), 32'd16);
            end
        end
        check_val("pwrup_wait_ok", 32'(first_cs_fall - rel_cyc >= PWRUP_WAIT), 32'd1);
    endtask

    // ---------------- Stimulus ----------------
    int base, rel_cyc, falls, n, first_in, first_out, cnt_in, cnt_out;
    logic ps;

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check_val("rst_sclk", 32'(spi_sclk), 32'd1);
        check_val("rst_mosi", 32'(spi_mosi), 32'd0);
        check_val("rst_z_data", 32'(z_data), 32'd0);
        check_val("rst_z_valid", 32'(z_valid), 32'd0);
        check_val("rst_init_done", 32'(init_done), 32'd0);
        check_val("rst_int2_sync", 32'(int2_sync), 32'd0);

        base = frame_q.size();
        rel_cyc = cyc;
        rst = 1'b1;
        wait_for_init(5000);
        check_cfg(base, rel_cyc);

        wait_for_zv(1500);
        check_val("z_dir_pos", 32'(z_data), 32'h334);
        fix0 = 8'hF0;
        fix1 = 8'hFE;
        wait_for_zv(1500);
        check_val("z_dir_neg", 32'(z_data), 32'h2F0);

        use_fixed = 1'b0;
        int2_rand = 1'b1;
        repeat (12) wait_for_zv(900);
        int2_rand = 1'b0;

        repeat (4) @(negedge clk);
        int2_req++;
        first_in = -1; first_out = -1; cnt_in = 0; cnt_out = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (int2_in) begin cnt_in++; if (first_in < 0) first_in = j; end
            if (int2_sync) begin cnt_out++; if (first_out < 0) first_out = j; end
        end
        check_val("int2_in_width", 32'(cnt_in), 32'd3);
        check_val("int2_sync_width", 32'(cnt_out), 32'd3);
        check_val("int2_sync_delay", 32'(first_out - first_in), 32'd2);

        n = 0;
        while (spi_cs_n !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_rd_started", 32'(spi_cs_n), 32'd0);
        falls = 0;
        n = 0;
        ps = spi_sclk;
        while (falls < 10 && n < 1000) begin
            @(negedge clk);
            n++;
            if (ps && !spi_sclk) falls++;
            ps = spi_sclk;
        end
        check_val("abort_tenth_sclk", 32'(falls), 32'd10);
        rst = 1'b0;
        #1;
        check_val("abort_cs_n", 32'(spi_cs_n), 32'd1);
        check_val("abort_sclk", 32'(spi_sclk), 32'd1);
        check_val("abort_mosi", 32'(spi_mosi), 32'd0);
        check_val("abort_z_data", 32'(z_data), 32'd0);
        check_val("abort_init_done", 32'(init_done), 32'd0);
        repeat (3) @(negedge clk);
        base = frame_q.size();
        rel_cyc = cyc;
        rst = 1'b1;
        wait_for_init(5000);
        check_cfg(base, rel_cyc);
        wait_for_zv(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/adxl_z_reader.md
ADXL_Z_READER -- requirements
Module: adxl_z_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, clk cycles per SCLK half-period (1 MHz SCLK at 50 MHz clk).
REQ-002 SHALL have parameter PWRUP_WAIT, default 100000, clk cycles idle after reset before the first transaction.
REQ-003 SHALL have parameter SAMPLE_DIV, default 500000, clk cycles between Z read requests (100 Hz).
REQ-004 SHALL have parameter CS_GAP, default 50, minimum clk cycles spi_cs_n stays high between transactions.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 spi_sclk  output  1  SPI clock, idles high.
REQ-008 spi_cs_n  output  1  chip select, active-low.
REQ-009 spi_mosi  output  1  master data out.
REQ-010 spi_miso  input  1  slave data in.
REQ-011 int2_in  input  1  raw accelerometer INT2 pin.
REQ-012 int2_sync  output  1  INT2 after a 2-flop synchronizer.
REQ-013 z_data  output  10  latest Z sample, two's complement, in the format seg_driver_Z consumes.
REQ-014 z_valid  output  1  one-cycle pulse when z_data updates.
REQ-015 init_done  output  1  high once the configuration writes have completed.

Function
REQ-016 SPI SHALL run in mode 3 (CPOL=1, CPHA=1): MOSI changes on SCLK falling edges, MISO is sampled on SCLK rising edges, MSB first.
REQ-017 spi_cs_n SHALL fall at least CLK_DIV cycles before the first SCLK falling edge and rise at least CLK_DIV cycles after the last rising edge.
REQ-018 FSM states SHALL be: PWRUP, CFG_FMT, CFG_BW, CFG_PWR, GAP, IDLE, RD_Z, UPDATE.
REQ-019 PWRUP SHALL count PWRUP_WAIT cycles, then go to CFG_FMT.
REQ-020 CFG_FMT SHALL write 0x31 <- 0x00 (DATA_FORMAT: 4-wire, ±2 g, 10-bit right-justified); CFG_BW SHALL write 0x2C <- 0x0A (100 Hz); CFG_PWR SHALL write 0x2D <- 0x08 (measure).
REQ-021 Each write SHALL be 16 SCLK cycles: command byte {R=0, MB=0, addr[5:0]}, then the data byte.
REQ-022 Every transaction SHALL be followed by GAP (CS_GAP cycles) before the next state; after CFG_PWR's gap, init_done SHALL go high and the FSM SHALL enter IDLE.
REQ-023 A free-running sample counter SHALL wrap at SAMPLE_DIV-1 and set a single pending flag; ticks arriving while the flag is already set SHALL be dropped.
REQ-024 In IDLE with pending set, the FSM SHALL clear pending and enter RD_Z.
REQ-025 RD_Z SHALL be 24 SCLK cycles: command 0xF6 (R=1, MB=1, addr 0x36), then read DATAZ0 and DATAZ1; MOSI SHALL be 0 during the read bytes.
REQ-026 UPDATE SHALL set z_data = {DATAZ1[1:0], DATAZ0[7:0]} and pulse z_valid for exactly one cycle, then go to GAP and return to IDLE.
REQ-027 z_valid latency SHALL be 1 clk after the final SCLK rising edge of RD_Z.
REQ-028 z_data SHALL hold its value between updates; DATAZ1[7:2] SHALL be ignored.
REQ-029 int2_sync SHALL equal int2_in delayed by 2 clk cycles, independent of the FSM state.

Reset
REQ-030 When rst is low, outputs SHALL immediately be: spi_cs_n=1, spi_sclk=1, spi_mosi=0, z_data=0, z_valid=0, init_done=0, int2_sync=0.
REQ-031 Reset mid-transaction SHALL abort it without completing the byte, clear pending, and restart from PWRUP.
REQ-032 All counters and shift registers SHALL reset to 0.

Structure
REQ-033 A shared package SHALL hold the register addresses (0x31, 0x2C, 0x2D, 0x36), the config values, the read command 0xF6, and the FSM state encoding.
REQ-034 A sub-module spi_byte_engine SHALL shift a programmable 16- or 24-bit frame and return a done pulse; adxl_z_reader SHALL sequence it.

Verification
REQ-035 Reset release with a slave model -> after PWRUP_WAIT, MOSI frames 0x3100, 0x2C0A, 0x2D08 in order, then init_done=1.
REQ-036 Model returns DATAZ0=0x34, DATAZ1=0x03 -> z_data=0x334 with a single one-cycle z_valid.
REQ-037 Model returns DATAZ0=0xF0, DATAZ1=0xFE -> z_data=0x2F0 (negative -272).
REQ-038 SAMPLE_DIV=400 with a 24-bit read at CLK_DIV=4 -> reads start no closer than CS_GAP apart, none lost, no double z_valid.
REQ-039 rst asserted during the 10th SCLK of RD_Z -> cs_n=1 and sclk=1 in the same cycle, z_data=0; sequence restarts at PWRUP.
REQ-040 int2_in pulse of 3 cycles -> int2_sync pulse of 3 cycles, delayed by 2.
